// File: rtl/online_mult_pkg.sv
// Shared encodings and configuration check for the online multiplier sequencer.
package online_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_INIT = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  function automatic bit params_ok(input int n, input int delta, input int addr_w);
    return (n >= 1) && (n <= 120) && (delta >= 1) && (delta <= 7) &&
           (addr_w >= 1) && (addr_w <= 30) && ((n + delta) <= (1 << addr_w));
  endfunction

endpackage

// File: rtl/online_mult_sequencer_sanitize.sv
// Signed-digit sanitizer: the unused {1,1} code is forced to zero and flagged.
module sd_digit_sanitize
  import online_mult_pkg::*;
(
  input  logic [1:0] digit,
  output logic [1:0] clean,
  output logic       illegal
);

  assign illegal = (digit == (DIG_POS | DIG_NEG));
  assign clean   = illegal ? DIG_ZERO : digit;

endmodule

// File: rtl/online_mult_sequencer.sv
// Iteration sequencer for the radix-2 online multiplier: paces digit streams,
// drives the datapath controls and residual RAM addressing.
module online_mult_sequencer
  import online_mult_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DELTA    = 3,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        x_digit,
  input  logic [1:0]        y_digit,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        p_digit,
  output logic [1:0]        dp_x,
  output logic [1:0]        dp_y,
  output logic              dp_clear,
  output logic              dp_enable,
  output logic              dp_we,
  output logic [1:0]        dp_state,
  output logic [ADDR_W-1:0] cycle,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        out_digit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              proto_err
);

  if (!params_ok(N_DIGITS, DELTA, ADDR_W)) begin : g_bad_cfg
    $error("online_mult_sequencer: illegal N_DIGITS/DELTA/ADDR_W");
  end

  localparam logic [ADDR_W-1:0] N_L    = ADDR_W'(N_DIGITS);
  localparam logic [ADDR_W-1:0] D_L    = ADDR_W'(DELTA);
  localparam logic [ADDR_W-1:0] LAST_L = ADDR_W'(N_DIGITS + DELTA - 1);
  localparam logic [ADDR_W-1:0] ONE_L  = ADDR_W'(1);

  state_e            state;
  logic [ADDR_W-1:0] cycle_q;
  logic              proto_err_q;

  // lane 1 = x, lane 0 = y
  logic [1:0][1:0] raw_dig, san_dig;
  logic [1:0]      illegal;

  assign raw_dig = {x_digit, y_digit};

  for (genvar i = 0; i < 2; i++) begin : g_san
    sd_digit_sanitize u_san (
      .digit   (raw_dig[i]),
      .clean   (san_dig[i]),
      .illegal (illegal[i])
    );
  end

  logic run, head, emit, step;

  assign run  = (state == ST_RUN);
  assign head = run && (cycle_q < N_L);
  assign emit = run && (cycle_q >= D_L);
  // Both handshakes retire in the same step, keeping input and output counts locked.
  assign step = run && !abort && (!head || in_valid) && (!emit || out_ready);

  assign in_ready  = head && (!emit || out_ready);
  assign out_valid = emit && (!head || in_valid);
  assign out_digit = out_valid ? p_digit : DIG_ZERO;
  assign dp_x      = head ? san_dig[1] : DIG_ZERO;
  assign dp_y      = head ? san_dig[0] : DIG_ZERO;
  assign dp_enable = step;
  assign dp_we     = step;
  assign dp_clear  = (state == ST_INIT);
  assign dp_state  = state;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign proto_err = proto_err_q;
  assign cycle     = cycle_q;
  assign wr_addr   = cycle_q;
  assign rd_addr   = (cycle_q == '0) ? '0 : cycle_q - ONE_L;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cycle_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_INIT;
        ST_INIT: begin
          cycle_q     <= '0;
          proto_err_q <= 1'b0;
          state       <= abort ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          if (abort) begin
            state   <= ST_IDLE;
            cycle_q <= '0;
          end else if (step) begin
            cycle_q <= cycle_q + ONE_L;
            if (head && (|illegal)) proto_err_q <= 1'b1;
            if (cycle_q == LAST_L) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          cycle_q <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_online_mult_sequencer.sv
// Scoreboard bench for online_mult_sequencer: directed operations with stalls,
// illegal digits, abort, start filtering and mid-operation reset.
module tb_online_mult_sequencer;
  localparam int N  = 8;
  localparam int D  = 3;
  localparam int AW = 7;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] x_digit, y_digit, p_digit, dp_x, dp_y, out_digit, dp_state;
  logic in_ready, dp_clear, dp_enable, dp_we, out_valid, busy, done, proto_err;
  logic [AW-1:0] cycle, wr_addr, rd_addr;

  logic [1:0] xtab [N];
  logic [1:0] ytab [N];
  logic [1:0] ptab [N];
  int iidx, pidx;

  logic [1:0] exp_out[$], exp_dx[$], exp_dy[$];
  int checks = 0, errors = 0;
  int in_cnt, out_cnt, dones, clears, step_idx = 0, ill_j = -1;

  always #5 clk = ~clk;

  online_mult_sequencer #(.N_DIGITS(N), .DELTA(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_digit(x_digit), .y_digit(y_digit), .in_valid(in_valid), .in_ready(in_ready),
    .p_digit(p_digit), .dp_x(dp_x), .dp_y(dp_y), .dp_clear(dp_clear),
    .dp_enable(dp_enable), .dp_we(dp_we), .dp_state(dp_state), .cycle(cycle),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .out_digit(out_digit), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .proto_err(proto_err)
  );

  // Digit source and product-digit datapath stand-in, advanced by completed handshakes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iidx <= 0;
      pidx <= 0;
    end else if (dp_clear) begin
      iidx <= 0;
      pidx <= 0;
    end else begin
      if (in_valid && in_ready) iidx <= iidx + 1;
      if (out_valid && out_ready) pidx <= pidx + 1;
    end
  end

  assign x_digit = (iidx < N) ? xtab[iidx[2:0]] : 2'b00;
  assign y_digit = (iidx < N) ? ytab[iidx[2:0]] : 2'b00;
  assign p_digit = (pidx < N) ? ptab[pidx[2:0]] : 2'b00;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] san(input logic [1:0] d);
    return (d == 2'b11) ? 2'b00 : d;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT moves data.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (dp_clear) begin step_idx = 0; clears++; end
      if (done) dones++;
      if (in_valid && in_ready) in_cnt++;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_out.size() == 0) chk("out_extra", 1, 0);
        else chk("out_digit", int'(out_digit), int'(exp_out.pop_front()));
      end
      if (dp_enable) begin
        chk("step_cycle", int'(cycle), step_idx);
        chk("step_wr_addr", int'(wr_addr), step_idx);
        chk("step_rd_addr", int'(rd_addr), (step_idx == 0) ? 0 : step_idx - 1);
        chk("step_we", int'(dp_we), 1);
        if (step_idx < N) begin
          chk("step_in_hs", int'(in_valid && in_ready), 1);
          if (exp_dx.size() == 0) chk("dp_extra", 1, 0);
          else begin
            chk("dp_x", int'(dp_x), int'(exp_dx.pop_front()));
            chk("dp_y", int'(dp_y), int'(exp_dy.pop_front()));
          end
        end else begin
          chk("tail_dp_x", int'(dp_x), 0);
          chk("tail_dp_y", int'(dp_y), 0);
          chk("tail_in_ready", int'(in_ready), 0);
        end
        step_idx++;
      end
    end
  end

  // One operation. Negative j arguments disable that event.
  task automatic run_op(input int sj, input int slen, input int bj, input int blen,
                        input int aj, input int rj, input int srj, input bit sa,
                        input int exp_lat);
    int scnt = 0, bcnt = 0, lat = 0;
    bit fin = 0, cut = 0;
    exp_out.delete(); exp_dx.delete(); exp_dy.delete();
    for (int i = 0; i < N; i++) begin
      exp_out.push_back(ptab[i]);
      exp_dx.push_back(san(xtab[i]));
      exp_dy.push_back(san(ytab[i]));
    end
    in_cnt = 0; out_cnt = 0; dones = 0; clears = 0;
    in_valid = 1; out_ready = 1; start = 1; abort = sa;
    @(posedge clk); #1;
    start = 0; abort = 0; lat = 1;
    if (sa) begin
      chk("sa_state", int'(dp_state), 1);
      chk("sa_clear", int'(dp_clear), 1);
    end
    for (int k = 0; k < 200; k++) begin
      in_valid = 1; out_ready = 1; start = 0;
      if (dp_state == 2'b10) begin
        if (int'(cycle) == sj && scnt < slen) begin in_valid = 0; scnt++; end
        if (int'(cycle) == bj && bcnt < blen) begin out_ready = 0; bcnt++; end
        if (int'(cycle) == srj) start = 1;
        if (int'(cycle) == ill_j) chk("ill_dp_x", int'(dp_x), 0);
        chk("proto_err", int'(proto_err), int'(ill_j >= 0 && int'(cycle) > ill_j));
        if (int'(cycle) == aj) begin
          abort = 1;
          @(posedge clk); #1;
          abort = 0;
          chk("abort_busy", int'(busy), 0);
          chk("abort_state", int'(dp_state), 0);
          chk("abort_cycle", int'(cycle), 0);
          repeat (4) @(posedge clk);
          #1;
          chk("abort_no_done", dones, 0);
          cut = 1;
          break;
        end
        if (int'(cycle) == rj) begin
          rst_n = 0;
          #1;
          chk("rst_ctrl", int'({in_ready, dp_clear, dp_enable, dp_we, out_valid, busy, done, proto_err}), 0);
          chk("rst_digits", int'({dp_x, dp_y, out_digit, dp_state}), 0);
          chk("rst_addr", int'({cycle, wr_addr, rd_addr}), 0);
          @(negedge clk);
          rst_n = 1;
          @(posedge clk); #1;
          chk("rst_no_done", dones, 0);
          chk("rst_idle", int'(dp_state), 0);
          cut = 1;
          break;
        end
      end
      @(negedge clk);
      if (dp_state == 2'b10) begin
        if (!in_valid) begin
          chk("starve_cycle", int'(cycle), sj);
          chk("starve_en", int'(dp_enable), 0);
          chk("starve_we", int'(dp_we), 0);
          if (sj >= D) chk("starve_out_valid", int'(out_valid), 0);
        end
        if (!out_ready) begin
          chk("bp_cycle", int'(cycle), bj);
          chk("bp_in_ready", int'(in_ready), 0);
          chk("bp_en", int'(dp_enable), 0);
        end
        if (sj < 0 && bj < 0) begin
          chk("nom_in_ready", int'(in_ready), int'(cycle < N));
          chk("nom_out_valid", int'(out_valid), int'(cycle >= D));
        end
      end
      if (done) begin
        chk("done_busy", int'(busy), 1);
        chk("done_en", int'(dp_enable), 0);
        fin = 1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 0; out_ready = 0; start = 0; abort = 0;
    if (cut) begin
      exp_out.delete(); exp_dx.delete(); exp_dy.delete();
      return;
    end
    if (!fin) begin
      chk("timeout", 0, 1);
      return;
    end
    chk("latency", lat, exp_lat);
    chk("in_count", in_cnt, N);
    chk("out_count", out_cnt, N);
    chk("clear_count", clears, 1);
    chk("out_left", exp_out.size(), 0);
    @(posedge clk); #1;
    chk("done_pulses", dones, 1);
    chk("done_low", int'(done), 0);
    chk("back_idle", int'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      xtab[i] = 2'b10;
      ytab[i] = 2'b10;
    end
    ptab[0] = 2'b10; ptab[1] = 2'b01; ptab[2] = 2'b00; ptab[3] = 2'b10;
    ptab[4] = 2'b10; ptab[5] = 2'b01; ptab[6] = 2'b00; ptab[7] = 2'b01;

    #12;
    chk("reset_ctrl", int'({in_ready, dp_clear, dp_enable, dp_we, out_valid, busy, done, proto_err}), 0);
    chk("reset_state", int'(dp_state), 0);
    chk("reset_cycle", int'(cycle), 0);
    chk("reset_addr", int'({wr_addr, rd_addr}), 0);
    chk("reset_digits", int'({dp_x, dp_y, out_digit}), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // all-ones operands, no stalls
    run_op(-1, 0, -1, 0, -1, -1, -1, 1'b0, N + D + 2);

    xtab[0] = 2'b10; xtab[1] = 2'b01; xtab[2] = 2'b00; xtab[3] = 2'b10;
    xtab[4] = 2'b01; xtab[5] = 2'b01; xtab[6] = 2'b10; xtab[7] = 2'b00;
    ytab[0] = 2'b01; ytab[1] = 2'b10; ytab[2] = 2'b10; ytab[3] = 2'b00;
    ytab[4] = 2'b10; ytab[5] = 2'b01; ytab[6] = 2'b00; ytab[7] = 2'b10;

    run_op(2, 4, -1, 0, -1, -1, -1, 1'b0, N + D + 2 + 4);
    run_op(4, 2, -1, 0, -1, -1, -1, 1'b0, N + D + 2 + 2);
    run_op(-1, 0, 5, 3, -1, -1, -1, 1'b0, N + D + 2 + 3);
    run_op(-1, 0, 9, 2, -1, -1, -1, 1'b0, N + D + 2 + 2);

    xtab[1] = 2'b11; ill_j = 1;
    run_op(-1, 0, -1, 0, -1, -1, -1, 1'b0, N + D + 2);
    chk("proto_err_sticky", int'(proto_err), 1);
    xtab[1] = 2'b01; ill_j = -1;

    run_op(-1, 0, -1, 0, 6, -1, -1, 1'b0, 0);
    run_op(-1, 0, -1, 0, -1, -1, 3, 1'b0, N + D + 2);
    run_op(-1, 0, -1, 0, -1, -1, -1, 1'b1, N + D + 2);
    run_op(-1, 0, -1, 0, -1, 4, -1, 1'b0, 0);
    run_op(-1, 0, -1, 0, -1, -1, -1, 1'b0, N + D + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
